// File: rtl/multicore_pkg.sv
// Shared definitions for the multicore front end.
// Contents:
//   INST_SIZE / OFFSET / WORD_BITS : core-wide instruction and word sizes
//   fetch_state_t                  : fetch FSM states
//   fetch_entry_t                  : {pc, instr} pair handed from fetch to decode
package multicore_pkg;
  localparam int INST_SIZE       = 32;
  localparam int OFFSET          = 2;   // byte offset bits within an instruction word
  localparam int WORD_BITS       = 32;
  localparam int FETCH_ADDR_SIZE = 32;

  typedef enum logic {FETCH_IDLE, FETCH_REQ} fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_SIZE-1:0] pc;
    logic [INST_SIZE-1:0]       instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO between fetch and decode.
// Ports:
//   i_aclk, i_areset_n : clock, async active-low reset
//   i_push, i_entry    : write an entry (ignored when full unless popping)
//   i_pop              : remove head (ignored when empty)
//   i_flush            : drop all entries; wins over push and pop
//   o_head             : current head entry (zero after reset)
//   o_count            : occupancy 0..2
//   o_full, o_empty    : occupancy flags
module fetch_buffer
  import multicore_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       i_aclk,
  input  logic       i_areset_n,
  input  logic       i_push,
  input  entry_t     i_entry,
  input  logic       i_pop,
  input  logic       i_flush,
  output entry_t     o_head,
  output logic [1:0] o_count,
  output logic       o_full,
  output logic       o_empty
);
  entry_t     mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       push_ok, pop_ok;

  assign o_full  = (count == 2'd2);
  assign o_empty = (count == 2'd0);
  assign o_count = count;
  assign o_head  = mem[rd_ptr];

  assign pop_ok  = i_pop && !o_empty;
  // A full buffer still accepts a push when the head leaves the same cycle.
  assign push_ok = i_push && (!o_full || pop_ok);

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (i_flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= i_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one request at a time to the instruction
// cache, and queues {pc, instr} pairs for decode in a 2-entry buffer.
// Ports:
//   i_aclk, i_areset_n       : clock, async active-low reset
//   o_req, o_addr            : cache request, held until i_instr_valid
//   i_instr_valid            : cache completion pulse
//   i_instruction            : returned instruction
//   i_redirect, i_redirect_pc: PC change from execute (low 2 bits ignored)
//   o_valid, i_ready         : decode handshake
//   o_pc, o_instr            : head of the fetch buffer
module instruction_fetch
  import multicore_pkg::*;
#(
  parameter int                  ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  output logic                 o_req,
  output logic [ADDR_SIZE-1:0] o_addr,
  input  logic                 i_instr_valid,
  input  logic [INST_SIZE-1:0] i_instruction,
  input  logic                 i_redirect,
  input  logic [ADDR_SIZE-1:0] i_redirect_pc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ADDR_SIZE-1:0] o_pc,
  output logic [INST_SIZE-1:0] o_instr
);
  typedef struct packed {
    logic [ADDR_SIZE-1:0] pc;
    logic [INST_SIZE-1:0] instr;
  } entry_t;

  fetch_state_t         state;
  logic [ADDR_SIZE-1:0] pc_q, redir_q, target;
  logic                 kill_q;
  logic                 complete, push, pop;
  logic [1:0]           buf_count;
  logic                 buf_full, buf_empty;
  entry_t               push_entry, head;

  assign target   = {i_redirect_pc[ADDR_SIZE-1:OFFSET], {OFFSET{1'b0}}};
  assign complete = (state == FETCH_REQ) && i_instr_valid;
  // Data returning for a killed request, or alongside a new redirect, is stale.
  assign push     = complete && !kill_q && !i_redirect && !buf_full;
  assign pop      = o_valid && i_ready;

  assign push_entry = '{pc: pc_q, instr: i_instruction};

  fetch_buffer #(.entry_t(entry_t)) u_buf (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_push     (push),
    .i_entry    (push_entry),
    .i_pop      (pop),
    .i_flush    (i_redirect),
    .o_head     (head),
    .o_count    (buf_count),
    .o_full     (buf_full),
    .o_empty    (buf_empty)
  );

  // o_addr tracks pc_q directly: pc_q never changes while a request is
  // outstanding, which keeps the address stable until completion.
  assign o_req   = (state == FETCH_REQ);
  assign o_addr  = pc_q;
  assign o_valid = !buf_empty;
  assign o_pc    = head.pc;
  assign o_instr = head.instr;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state   <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (i_redirect)              pc_q  <= target;
          else if (buf_count < 2'd2)   state <= FETCH_REQ;
        end
        FETCH_REQ: begin
          if (i_instr_valid) begin
            state  <= FETCH_IDLE;
            kill_q <= 1'b0;
            if (i_redirect)  pc_q <= target;
            else if (kill_q) pc_q <= redir_q;
            else             pc_q <= pc_q + ADDR_SIZE'(4);
          end else if (i_redirect) begin
            // Cache cannot cancel: remember where to go once it answers.
            redir_q <= target;
            kill_q  <= 1'b1;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end
endmodule
